pipe_wb: RTL and testbench
==========================

# pipe_wb

Write-back stage of the five-stage MIPS pipeline: the producing end of the register-file write port (`wd`, `wa`, `rf_wena`) consumed by the decode stage. It latches the MEM/WB pipeline register and selects ALU result or load data. Loads are aligned and extended by `w`/`h`/`b` width, and misaligned loads and overflowing results are suppressed. It also keeps a retired-instruction counter.

## Interface
Parameters:
- `CNT_W`, 32, width of retired-instruction counter

Ports:
- `clk`  in  1  pipeline clock
- `rst`  in  1  asynchronous, active-high reset
- `valid_m`  in  1  MEM stage holds a real instruction
- `stall_m`  in  1  MEM stage stalled this cycle; WB latches a bubble
- `flush`  in  1  kill instruction entering WB; WB latches a bubble
- `alu_m`  in  32  ALU result / load address
- `mem_m`  in  32  raw data-memory word at `{alu_m[31:2],2'b00}`
- `wa_m`  in  5  destination register
- `wrf_m`  in  1  instruction writes register file
- `wdc_m`  in  1  1 = write-back data from memory (load), 0 = ALU
- `w_m`, `h_m`, `b_m`  in  1 each  load width: word / half / byte
- `sext_m`  in  1  sign-extend half/byte loads
- `overflow_m`  in  1  arithmetic overflow on this instruction
- `wd`  out  32  register write data
- `wa`  out  5  register write address
- `rf_wena`  out  1  register write enable
- `ade`  out  1  one-cycle pulse: misaligned load retired
- `retired`  out  CNT_W  count of valid instructions reaching WB

## Operation
- WB register fields: valid, alu, mem, wa, wrf, wdc, w, h, b, sext, overflow.
- Load rule: valid ← `valid_m & ~stall_m & ~flush`. All other fields load every cycle.
- Outputs are combinational from the WB register only. No combinational path from `*_m` inputs.
- Width priority: `w` > `h` > `b`. None set on a load counts as word.
- Byte order is big-endian. `off = alu[1:0]`.
  - byte: off 0→`mem[31:24]`, 1→`[23:16]`, 2→`[15:8]`, 3→`[7:0]`.
  - half: off 0→`[31:16]`, 2→`[15:0]`.
  - word: `mem`.
- Extension: half/byte are sign-extended when `sext`=1, else zero-extended to 32 bits.
- Misaligned: `valid & wdc` and either (word with off≠0) or (half with off[0]=1).
- `wd` = aligned load data when `wdc`=1, else `alu`.
- `wa` = WB register `wa`.
- `rf_wena` = `valid & wrf & ~overflow & ~misaligned & (wa≠0)`.
- `ade` = `valid & misaligned`.
- `retired` increments by 1 on every clock where WB valid=1, including suppressed writes. It wraps to 0 at all-ones.

## Timing
- Latency: one clock from `*_m` sampled at edge N to `wd`/`wa`/`rf_wena` valid after edge N. The decode stage writes the register file at edge N+1.
- Throughput: one instruction per clock. `stall_m` and `flush` each insert exactly one bubble per asserted cycle.
- `stall_m` and `flush` together give a single bubble.
- Reset value of every output: `wd`=0, `wa`=0, `rf_wena`=0, `ade`=0, `retired`=0. All WB register fields are 0.
- Reset mid-operation clears all state immediately, without waiting for a clock. The first instruction is latched on the first edge after `rst` deasserts.
- `ade` is high for exactly the one cycle the offending instruction occupies WB.

## Structure
- Shared package `pipe_pkg`:
  - byte-offset constants `OFF_B0..OFF_B3`.
  - width-select encoding `LW_WORD/LW_HALF/LW_BYTE`.
  - `REG_ZERO = 5'd0`.
- Sub-module `load_align` (combinational) holds the alignment, extension and misalignment logic. Inputs: `mem`, `off`, `w/h/b`, `sext`. Outputs: `data`, `misaligned`.
- `pipe_wb` holds the WB register, output muxing, the enable qualification and the counter.

## Test plan
- ALU write: `alu_m`=0x0000_1234, `wa_m`=8, `wrf_m`=1, `wdc_m`=0 → next cycle `wd`=0x0000_1234, `wa`=8, `rf_wena`=1, `retired`=1 one cycle later.
- Byte load signed: `mem_m`=0x12F4_5678, off 1, `b_m`=1, `sext_m`=1 → `wd`=0xFFFF_FFF4. Same with `sext_m`=0 → `wd`=0x0000_00F4.
- Half load: `mem_m`=0x8001_7FFF, off 2, `h_m`=1, `sext_m`=1 → `wd`=0x0000_7FFF. Off 0 → `wd`=0xFFFF_8001.
- Misaligned word: off 2, `w_m`=1, `wdc_m`=1 → `rf_wena`=0, `ade` pulse 1 cycle, `retired` still increments.
- Suppression: `overflow_m`=1 → `rf_wena`=0. `wa_m`=0 → `rf_wena`=0.
- Bubbles and reset: `stall_m`=1 and `flush`=1 on the same cycle → one bubble (`rf_wena`=0, counter unchanged). Async `rst` pulse between edges → all outputs 0 immediately. Counter preset near max wraps 0xFFFF_FFFF→0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline constants and types for the write-back stage.
package pipe_pkg;

    localparam logic [1:0] OFF_B0 = 2'd0;
    localparam logic [1:0] OFF_B1 = 2'd1;
    localparam logic [1:0] OFF_B2 = 2'd2;
    localparam logic [1:0] OFF_B3 = 2'd3;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        LW_WORD = 2'd0,
        LW_HALF = 2'd1,
        LW_BYTE = 2'd2
    } lw_sel_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [4:0]  wa;
        logic        wrf;
        logic        wdc;
        logic        w;
        logic        h;
        logic        b;
        logic        sext;
        logic        overflow;
    } wb_reg_t;

    // Word wins over half wins over byte; no width flag at all means word.
    function automatic lw_sel_e lw_select(input logic w, input logic h, input logic b);
        if (w)      return LW_WORD;
        else if (h) return LW_HALF;
        else if (b) return LW_BYTE;
        else        return LW_WORD;
    endfunction

endpackage

// File: rtl/pipe_wb_if.sv
// MEM/WB pipeline bus plus the register-file write port produced by WB.
interface pipe_wb_if;

    logic        valid_m;
    logic        stall_m;
    logic        flush;
    logic [31:0] alu_m;
    logic [31:0] mem_m;
    logic [4:0]  wa_m;
    logic        wrf_m;
    logic        wdc_m;
    logic        w_m;
    logic        h_m;
    logic        b_m;
    logic        sext_m;
    logic        overflow_m;

    logic [31:0] wd;
    logic [4:0]  wa;
    logic        rf_wena;
    logic        ade;

    modport master (
        output valid_m, stall_m, flush, alu_m, mem_m, wa_m, wrf_m, wdc_m,
               w_m, h_m, b_m, sext_m, overflow_m,
        input  wd, wa, rf_wena, ade
    );

    modport slave (
        input  valid_m, stall_m, flush, alu_m, mem_m, wa_m, wrf_m, wdc_m,
               w_m, h_m, b_m, sext_m, overflow_m,
        output wd, wa, rf_wena, ade
    );

endinterface

// File: rtl/pipe_wb_load_align.sv
// Big-endian load alignment, sign/zero extension and misalignment detection.
module load_align
    import pipe_pkg::*;
(
    input  logic [31:0] mem,
    input  logic [1:0]  off,
    input  logic        w,
    input  logic        h,
    input  logic        b,
    input  logic        sext,
    output logic [31:0] data,
    output logic        misaligned
);

    lw_sel_e     sel;
    logic [15:0] half;
    logic [7:0]  byte_d;

    always_comb begin
        sel        = lw_select(w, h, b);
        half       = off[1] ? mem[15:0] : mem[31:16];
        byte_d     = mem[31:24];
        data       = mem;
        misaligned = 1'b0;

        case (off)
            OFF_B0:  byte_d = mem[31:24];
            OFF_B1:  byte_d = mem[23:16];
            OFF_B2:  byte_d = mem[15:8];
            OFF_B3:  byte_d = mem[7:0];
            default: byte_d = mem[31:24];
        endcase

        case (sel)
            LW_HALF: begin
                data       = sext ? {{16{half[15]}}, half} : {16'h0000, half};
                misaligned = off[0];
            end
            LW_BYTE: begin
                data = sext ? {{24{byte_d[7]}}, byte_d} : {24'h000000, byte_d};
            end
            default: begin
                data       = mem;
                misaligned = (off != OFF_B0);
            end
        endcase
    end

endmodule

// File: rtl/pipe_wb.sv
// Write-back stage: MEM/WB register, load/ALU select, write-enable qualification
// and retired-instruction counter.
module pipe_wb
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    pipe_wb_if.slave         bus,
    output logic [CNT_W-1:0] retired
);

    wb_reg_t     wb;
    logic [31:0] ld_data;
    logic        ld_mis;
    logic        misaligned;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb      <= '0;
            retired <= '0;
        end else begin
            wb.valid    <= bus.valid_m & ~bus.stall_m & ~bus.flush;
            wb.alu      <= bus.alu_m;
            wb.mem      <= bus.mem_m;
            wb.wa       <= bus.wa_m;
            wb.wrf      <= bus.wrf_m;
            wb.wdc      <= bus.wdc_m;
            wb.w        <= bus.w_m;
            wb.h        <= bus.h_m;
            wb.b        <= bus.b_m;
            wb.sext     <= bus.sext_m;
            wb.overflow <= bus.overflow_m;
            // Suppressed writes still retire; counter wraps naturally at all-ones.
            if (wb.valid)
                retired <= retired + CNT_W'(1);
        end
    end

    load_align u_align (
        .mem        (wb.mem),
        .off        (wb.alu[1:0]),
        .w          (wb.w),
        .h          (wb.h),
        .b          (wb.b),
        .sext       (wb.sext),
        .data       (ld_data),
        .misaligned (ld_mis)
    );

    always_comb begin
        misaligned  = wb.valid & wb.wdc & ld_mis;
        bus.wd      = wb.wdc ? ld_data : wb.alu;
        bus.wa      = wb.wa;
        bus.rf_wena = wb.valid & wb.wrf & ~wb.overflow & ~misaligned & (wb.wa != REG_ZERO);
        bus.ade     = misaligned;
    end

endmodule

// File: tb/tb_pipe_wb.sv
// Self-checking bench for pipe_wb: behavioural WB model compared every cycle,
// plus hand-computed expectations from the test plan.
module tb_pipe_wb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst4 = 1'b1;
    logic [31:0] retired;
    logic [3:0]  retired4;

    int compared   = 0;
    int mismatched = 0;
    bit wrap_done  = 1'b0;

    always #5 clk = ~clk;

    pipe_wb_if bus ();
    pipe_wb_if bus4 ();

    pipe_wb #(.CNT_W(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .retired (retired)
    );

    pipe_wb #(.CNT_W(4)) dut4 (
        .clk     (clk),
        .rst     (rst4),
        .bus     (bus4),
        .retired (retired4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          valid;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [4:0]  wa;
        bit          wrf, wdc, w, h, b, sext, ovf;
    } m_t;

    m_t          m;
    logic [31:0] m_cnt;

    function automatic bit m_is_word(m_t x);
        return x.w || (!x.h && !x.b);
    endfunction

    function automatic logic [31:0] m_wd(m_t x);
        int          off;
        logic [31:0] v;
        off = int'(x.alu % 4);
        if (!x.wdc) return x.alu;
        if (m_is_word(x)) return x.mem;
        if (x.h) begin
            v = (x.mem >> (16 * (1 - off / 2))) & 32'h0000_FFFF;
            if (x.sext && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = (x.mem >> (8 * (3 - off))) & 32'h0000_00FF;
            if (x.sext && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end
        return v;
    endfunction

    function automatic bit m_mis(m_t x);
        int off;
        off = int'(x.alu % 4);
        return x.valid && x.wdc && ((m_is_word(x) && off != 0) || (!m_is_word(x) && x.h && off % 2 == 1));
    endfunction

    function automatic bit m_wena(m_t x);
        return x.valid && x.wrf && !x.ovf && !m_mis(x) && x.wa != 5'd0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m     = '{default: 0};
            m_cnt = 32'd0;
        end else begin
            if (m.valid) m_cnt = m_cnt + 32'd1;
            m.valid = bus.valid_m && !bus.stall_m && !bus.flush;
            m.alu   = bus.alu_m;
            m.mem   = bus.mem_m;
            m.wa    = bus.wa_m;
            m.wrf   = bus.wrf_m;
            m.wdc   = bus.wdc_m;
            m.w     = bus.w_m;
            m.h     = bus.h_m;
            m.b     = bus.b_m;
            m.sext  = bus.sext_m;
            m.ovf   = bus.overflow_m;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("model_wd",      bus.wd,               m_wd(m));
            check("model_wa",      {27'd0, bus.wa},      {27'd0, m.wa});
            check("model_rf_wena", {31'd0, bus.rf_wena}, {31'd0, m_wena(m)});
            check("model_ade",     {31'd0, bus.ade},     {31'd0, m_mis(m)});
            check("model_retired", retired,              m_cnt);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit valid, input logic [31:0] alu, input logic [31:0] mem,
                         input logic [4:0] wa, input bit wrf, input bit wdc,
                         input bit w, input bit h, input bit b, input bit sext,
                         input bit ovf, input bit stall, input bit flsh);
        bus.valid_m    = valid;
        bus.alu_m      = alu;
        bus.mem_m      = mem;
        bus.wa_m       = wa;
        bus.wrf_m      = wrf;
        bus.wdc_m      = wdc;
        bus.w_m        = w;
        bus.h_m        = h;
        bus.b_m        = b;
        bus.sext_m     = sext;
        bus.overflow_m = ovf;
        bus.stall_m    = stall;
        bus.flush      = flsh;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bubble();
        drive(0, 32'd0, 32'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    logic [31:0] r0;

    initial begin
        bus4.valid_m    = 1'b1;
        bus4.stall_m    = 1'b0;
        bus4.flush      = 1'b0;
        bus4.alu_m      = '0;
        bus4.mem_m      = '0;
        bus4.wa_m       = '0;
        bus4.wrf_m      = 1'b0;
        bus4.wdc_m      = 1'b0;
        bus4.w_m        = 1'b0;
        bus4.h_m        = 1'b0;
        bus4.b_m        = 1'b0;
        bus4.sext_m     = 1'b0;
        bus4.overflow_m = 1'b0;
        @(negedge clk);
        check("cnt4_reset", {28'd0, retired4}, 32'd0);
        rst4 = 1'b0;
        repeat (16) @(posedge clk);
        @(negedge clk);
        check("cnt4_max", {28'd0, retired4}, 32'd15);
        @(posedge clk);
        @(negedge clk);
        check("cnt4_wrap", {28'd0, retired4}, 32'd0);
        wrap_done = 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bubble();
        @(negedge clk);
        @(negedge clk);
        check("rst_wd",      bus.wd,               32'd0);
        check("rst_wa",      {27'd0, bus.wa},      32'd0);
        check("rst_rf_wena", {31'd0, bus.rf_wena}, 32'd0);
        check("rst_ade",     {31'd0, bus.ade},     32'd0);
        check("rst_retired", retired,              32'd0);
        rst = 1'b0;

        // ALU write
        drive(1, 32'h0000_1234, 32'hDEAD_BEEF, 5'd8, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        check("alu_wd", bus.wd, 32'h0000_1234);
        check("alu_wa", {27'd0, bus.wa}, 32'd8);
        check("alu_wena", {31'd0, bus.rf_wena}, 32'd1);
        check("alu_retired_before", retired, 32'd0);
        bubble();
        step();
        check("alu_retired_after", retired, 32'd1);

        // byte loads
        drive(1, 32'h0000_0101, 32'h12F4_5678, 5'd3, 1, 1, 0, 0, 1, 1, 0, 0, 0);
        step();
        check("lb_sext", bus.wd, 32'hFFFF_FFF4);
        check("lb_sext_wena", {31'd0, bus.rf_wena}, 32'd1);
        drive(1, 32'h0000_0101, 32'h12F4_5678, 5'd3, 1, 1, 0, 0, 1, 0, 0, 0, 0);
        step();
        check("lbu", bus.wd, 32'h0000_00F4);
        drive(1, 32'h0000_0100, 32'h12F4_5678, 5'd3, 1, 1, 0, 0, 1, 1, 0, 0, 0);
        step();
        check("lb_off0", bus.wd, 32'h0000_0012);
        drive(1, 32'h0000_0103, 32'h12F4_56F8, 5'd3, 1, 1, 0, 0, 1, 1, 0, 0, 0);
        step();
        check("lb_off3", bus.wd, 32'hFFFF_FFF8);
        drive(1, 32'h0000_0102, 32'h12F4_5678, 5'd3, 1, 1, 0, 1, 1, 1, 0, 0, 0);
        step();
        check("lh_over_lb", bus.wd, 32'h0000_5678);

        // half loads
        drive(1, 32'h0000_0002, 32'h8001_7FFF, 5'd9, 1, 1, 0, 1, 0, 1, 0, 0, 0);
        step();
        check("lh_off2", bus.wd, 32'h0000_7FFF);
        drive(1, 32'h0000_0000, 32'h8001_7FFF, 5'd9, 1, 1, 0, 1, 0, 1, 0, 0, 0);
        step();
        check("lh_off0", bus.wd, 32'hFFFF_8001);
        drive(1, 32'h0000_0001, 32'h8001_7FFF, 5'd9, 1, 1, 0, 1, 0, 1, 0, 0, 0);
        step();
        check("lh_mis_wena", {31'd0, bus.rf_wena}, 32'd0);
        check("lh_mis_ade", {31'd0, bus.ade}, 32'd1);
        drive(1, 32'h0000_0003, 32'hCAFE_F00D, 5'd9, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        step();
        check("no_width_is_word", {31'd0, bus.ade}, 32'd1);

        // misaligned word load
        drive(1, 32'h0000_0042, 32'h0BAD_F00D, 5'd4, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        step();
        check("lw_mis_wena", {31'd0, bus.rf_wena}, 32'd0);
        check("lw_mis_ade", {31'd0, bus.ade}, 32'd1);
        r0 = retired;
        drive(1, 32'h0000_0040, 32'h0BAD_F00D, 5'd4, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        step();
        check("lw_ok_ade", {31'd0, bus.ade}, 32'd0);
        check("lw_ok_wd", bus.wd, 32'h0BAD_F00D);
        check("lw_mis_retired", retired, r0 + 32'd1);

        // suppression
        drive(1, 32'h7FFF_FFFF, 32'd0, 5'd10, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        step();
        check("ovf_wena", {31'd0, bus.rf_wena}, 32'd0);
        drive(1, 32'h0000_0055, 32'd0, 5'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        check("r0_wena", {31'd0, bus.rf_wena}, 32'd0);
        drive(1, 32'h0000_0055, 32'd0, 5'd11, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        check("nowrf_wena", {31'd0, bus.rf_wena}, 32'd0);

        // bubbles
        drive(1, 32'h0000_0066, 32'd0, 5'd5, 1, 0, 0, 0, 0, 0, 0, 1, 1);
        step();
        check("stall_flush_wena", {31'd0, bus.rf_wena}, 32'd0);
        r0 = retired;
        drive(1, 32'h0000_0067, 32'd0, 5'd5, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        step();
        check("stall_wena", {31'd0, bus.rf_wena}, 32'd0);
        check("bubble_retired", retired, r0);
        drive(1, 32'h0000_0068, 32'd0, 5'd5, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        check("flush_wena", {31'd0, bus.rf_wena}, 32'd0);
        drive(1, 32'h0000_0069, 32'd0, 5'd5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        check("after_bubble_wena", {31'd0, bus.rf_wena}, 32'd1);
        check("after_bubble_retired", retired, r0);

        // asynchronous reset between edges
        drive(1, 32'h0000_0070, 32'd0, 5'd6, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        check("pre_rst_wena", {31'd0, bus.rf_wena}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_wd",      bus.wd,               32'd0);
        check("async_wa",      {27'd0, bus.wa},      32'd0);
        check("async_wena",    {31'd0, bus.rf_wena}, 32'd0);
        check("async_ade",     {31'd0, bus.ade},     32'd0);
        check("async_retired", retired,              32'd0);
        #1;
        rst = 1'b0;
        drive(1, 32'h0000_0ABC, 32'd0, 5'd7, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        check("post_rst_wd", bus.wd, 32'h0000_0ABC);
        check("post_rst_wena", {31'd0, bus.rf_wena}, 32'd1);
        check("post_rst_retired", retired, 32'd0);
        bubble();
        step();
        check("post_rst_retired1", retired, 32'd1);
        step();

        while (!wrap_done) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
